// File: rtl/ccip_mmio_csr_responder.sv
// AFU-side CCI-P MMIO CSR responder: small CSR file plus a buffered read-response channel.
// Optional macro CCIP_MMIO_TIMESTAMP_EN adds a free-running 64-bit cycle counter at CSR 6.
module ccip_mmio_csr_responder #(
  parameter logic [63:0] AFU_DFH        = 64'h1000_0000_0000_0000,
  parameter logic [63:0] AFU_ID_L       = 64'h0,
  parameter logic [63:0] AFU_ID_H       = 64'h0,
  parameter int          RSP_FIFO_DEPTH = 4
) (
  input  logic        vl_clk_LPdomain_16ui,
  input  logic        ffs_vl_LP32ui_lp2sy_SoftReset,
  input  logic        mmio_req_valid,
  input  logic        mmio_req_write,
  input  logic [15:0] mmio_req_addr,
  input  logic [1:0]  mmio_req_len,
  input  logic [8:0]  mmio_req_tid,
  input  logic [63:0] mmio_req_data,
  output logic        mmio_rsp_valid,
  input  logic        mmio_rsp_ready,
  output logic [8:0]  mmio_rsp_tid,
  output logic [63:0] mmio_rsp_data,
  output logic [63:0] csr_ctl,
  input  logic [63:0] afu_status,
  output logic        err_overflow
);

  localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic        clk;
  logic        rst;
  logic [14:0] req_idx;
  logic        req_dw;
  logic        req_full;
  logic        req_wr;
  logic [63:0] scratch;
  logic [63:0] ctl;
  logic [63:0] qword;
  logic [63:0] rd_data;

  assign clk      = vl_clk_LPdomain_16ui;
  assign rst      = ffs_vl_LP32ui_lp2sy_SoftReset;
  assign req_idx  = mmio_req_addr[15:1];
  assign req_dw   = mmio_req_addr[0];
  assign req_full = (mmio_req_len != 2'd0);
  assign req_wr   = mmio_req_valid && mmio_req_write;

  function automatic logic [63:0] merge_write(input logic [63:0] old_val,
                                              input logic [63:0] wdata,
                                              input logic        full,
                                              input logic        dw);
    if (full)
      return wdata;
    else if (dw)
      return {wdata[31:0], old_val[31:0]};
    else
      return {old_val[63:32], wdata[31:0]};
  endfunction

`ifdef CCIP_MMIO_TIMESTAMP_EN
  logic [63:0] timestamp;

  always_ff @(posedge clk) begin
    if (rst)
      timestamp <= '0;
    else
      timestamp <= timestamp + 64'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scratch <= '0;
      ctl     <= '0;
    end else if (req_wr) begin
      if (req_idx == 15'd3)
        scratch <= merge_write(scratch, mmio_req_data, req_full, req_dw);
      if (req_idx == 15'd4)
        ctl <= merge_write(ctl, mmio_req_data, req_full, req_dw);
    end
  end

  // Reads see CSR state before this cycle's edge, so a write is visible one cycle later.
  always_comb begin
    qword = '0;
    case (req_idx)
      15'd0:   qword = AFU_DFH;
      15'd1:   qword = AFU_ID_L;
      15'd2:   qword = AFU_ID_H;
      15'd3:   qword = scratch;
      15'd4:   qword = ctl;
      15'd5:   qword = afu_status;
`ifdef CCIP_MMIO_TIMESTAMP_EN
      15'd6:   qword = timestamp;
`endif
      default: qword = '0;
    endcase
  end

  assign rd_data = req_full ? qword : {32'h0, (req_dw ? qword[63:32] : qword[31:0])};

  logic        s1_valid;
  logic [8:0]  s1_tid;
  logic [63:0] s1_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_tid   <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= mmio_req_valid && !mmio_req_write;
      s1_tid   <= mmio_req_tid;
      s1_data  <= rd_data;
    end
  end

  logic [72:0]      fifo_mem [RSP_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             pop;
  logic             push_ok;
  logic [72:0]      head;

  assign fifo_full = (count == CNT_W'(RSP_FIFO_DEPTH));
  assign pop       = mmio_rsp_valid && mmio_rsp_ready;
  // A simultaneous pop frees the slot, so a full FIFO can still accept the push.
  assign push_ok   = s1_valid && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wr_ptr] <= {s1_tid, s1_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (s1_valid && !push_ok)
        err_overflow <= 1'b1;
    end
  end

  assign head           = fifo_mem[rd_ptr];
  assign mmio_rsp_valid = (count != '0);
  assign mmio_rsp_tid   = mmio_rsp_valid ? head[72:64] : 9'h0;
  assign mmio_rsp_data  = mmio_rsp_valid ? head[63:0] : 64'h0;
  assign csr_ctl        = ctl;

endmodule

// File: tb/tb_ccip_mmio_csr_responder.sv
// Directed self-checking bench for ccip_mmio_csr_responder.
// Honours CCIP_MMIO_TIMESTAMP_EN so the timestamp expectations follow the build.
module tb_ccip_mmio_csr_responder;

  localparam logic [63:0] DFH  = 64'h1000_0000_0000_0000;
  localparam logic [63:0] IDL  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] IDH  = 64'h5555_6666_7777_8888;
  localparam logic [63:0] STAT = 64'hCAFE_F00D_0BAD_BEEF;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_addr;
  logic [1:0]  req_len;
  logic [8:0]  req_tid;
  logic [63:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;
  logic [63:0] csr_ctl;
  logic [63:0] afu_status;
  logic        err_overflow;

  int n_checks;
  int n_fail;

  ccip_mmio_csr_responder #(
    .AFU_DFH(DFH),
    .AFU_ID_L(IDL),
    .AFU_ID_H(IDH),
    .RSP_FIFO_DEPTH(4)
  ) dut (
    .vl_clk_LPdomain_16ui(clk),
    .ffs_vl_LP32ui_lp2sy_SoftReset(reset),
    .mmio_req_valid(req_valid),
    .mmio_req_write(req_write),
    .mmio_req_addr(req_addr),
    .mmio_req_len(req_len),
    .mmio_req_tid(req_tid),
    .mmio_req_data(req_data),
    .mmio_rsp_valid(rsp_valid),
    .mmio_rsp_ready(rsp_ready),
    .mmio_rsp_tid(rsp_tid),
    .mmio_rsp_data(rsp_data),
    .csr_ctl(csr_ctl),
    .afu_status(afu_status),
    .err_overflow(err_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Presents one request for exactly one cycle; returns 1 time unit after the sampling edge.
  task automatic issue(input logic wr, input logic [15:0] addr, input logic [1:0] len,
                       input logic [8:0] tid, input logic [63:0] data);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_len   = len;
    req_tid   = tid;
    req_data  = data;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(3);
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_valid: got %b, required 0", rsp_valid);
    end
    n_checks++;
    if (csr_ctl !== 64'h0) begin
      n_fail++; $display("[TB] FAIL reset_ctl: got %h, required 0", csr_ctl);
    end
    n_checks++;
    if (err_overflow !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_err: got %b, required 0", err_overflow);
    end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_read_dfh;
    rsp_ready = 1'b1;
    issue(1'b0, 16'h0000, 2'd1, 9'h05, 64'h0);
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL dfh_early_valid: got %b, required 0", rsp_valid);
    end
    idle(1);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_tid !== 9'h05 || rsp_data !== DFH) begin
      n_fail++;
      $display("[TB] FAIL dfh_read: got v=%b tid=%h data=%h, required v=1 tid=005 data=%h",
               rsp_valid, rsp_tid, rsp_data, DFH);
    end
    n_checks++;
    if (err_overflow !== 1'b0) begin
      n_fail++; $display("[TB] FAIL dfh_err: got %b, required 0", err_overflow);
    end
    idle(1);
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL dfh_pop: got valid %b, required 0", rsp_valid);
    end
  endtask

  task automatic test_scratch;
    rsp_ready = 1'b1;
    issue(1'b1, 16'h0006, 2'd1, 9'h0, 64'hDEAD_BEEF_0123_4567);
    issue(1'b0, 16'h0007, 2'd0, 9'h07, 64'h0);
    idle(1);
    n_checks++;
    if (rsp_tid !== 9'h07 || rsp_data !== 64'h0000_0000_DEAD_BEEF) begin
      n_fail++;
      $display("[TB] FAIL scratch_hi_dw: got tid=%h data=%h, required tid=007 data=00000000deadbeef",
               rsp_tid, rsp_data);
    end
    issue(1'b0, 16'h0006, 2'd0, 9'h08, 64'h0);
    idle(1);
    n_checks++;
    if (rsp_data !== 64'h0000_0000_0123_4567) begin
      n_fail++; $display("[TB] FAIL scratch_lo_dw: got %h, required 0000000001234567", rsp_data);
    end
    idle(2);
  endtask

  task automatic test_ctl;
    rsp_ready = 1'b1;
    issue(1'b1, 16'h0008, 2'd0, 9'h0, 64'hFFFF_FFFF_A5A5_A5A5);
    n_checks++;
    if (csr_ctl !== 64'h0000_0000_A5A5_A5A5) begin
      n_fail++; $display("[TB] FAIL ctl_lo_write: got %h, required 00000000a5a5a5a5", csr_ctl);
    end
    issue(1'b1, 16'h0009, 2'd0, 9'h0, 64'hFFFF_FFFF_1234_5678);
    n_checks++;
    if (csr_ctl !== 64'h1234_5678_A5A5_A5A5) begin
      n_fail++; $display("[TB] FAIL ctl_hi_write: got %h, required 12345678a5a5a5a5", csr_ctl);
    end
    // len 3 is treated as an 8 B access
    issue(1'b0, 16'h0008, 2'd3, 9'h1FF, 64'h0);
    idle(1);
    n_checks++;
    if (rsp_tid !== 9'h1FF || rsp_data !== 64'h1234_5678_A5A5_A5A5) begin
      n_fail++;
      $display("[TB] FAIL ctl_read_len3: got tid=%h data=%h, required tid=1ff data=12345678a5a5a5a5",
               rsp_tid, rsp_data);
    end
    idle(2);
  endtask

  task automatic test_ro_and_unmapped;
    rsp_ready = 1'b1;
    issue(1'b1, 16'h0000, 2'd1, 9'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(1'b1, 16'h000A, 2'd1, 9'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(1'b0, 16'h0000, 2'd1, 9'h21, 64'h0);
    idle(1);
    n_checks++;
    if (rsp_data !== DFH) begin
      n_fail++; $display("[TB] FAIL ro_dfh_write: got %h, required %h", rsp_data, DFH);
    end
    issue(1'b0, 16'h000B, 2'd0, 9'h22, 64'h0);
    idle(1);
    n_checks++;
    if (rsp_data !== 64'h0000_0000_CAFE_F00D) begin
      n_fail++; $display("[TB] FAIL status_hi_dw: got %h, required 00000000cafef00d", rsp_data);
    end
    issue(1'b0, 16'h0020, 2'd1, 9'h23, 64'h0);
    idle(1);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 64'h0) begin
      n_fail++; $display("[TB] FAIL unmapped_read: got v=%b data=%h, required v=1 data=0",
                         rsp_valid, rsp_data);
    end
    idle(2);
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp_data [4];
    exp_data[0] = DFH;
    exp_data[1] = IDL;
    exp_data[2] = IDH;
    exp_data[3] = 64'hDEAD_BEEF_0123_4567;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_valid = (i < 4);
      req_write = 1'b0;
      req_addr  = 16'(2 * i);
      req_len   = 2'd1;
      req_tid   = 9'(10 + i);
      @(posedge clk); #1;
      if (i >= 1) begin
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_tid !== 9'(9 + i) || rsp_data !== exp_data[i-1]) begin
          n_fail++;
          $display("[TB] FAIL b2b_%0d: got v=%b tid=%h data=%h, required v=1 tid=%h data=%h",
                   i - 1, rsp_valid, rsp_tid, rsp_data, 9'(9 + i), exp_data[i-1]);
        end
      end
    end
    req_valid = 1'b0;
    idle(3);
  endtask

  task automatic test_full_push_pop;
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      issue(1'b0, 16'h0000, 2'd1, 9'(20 + k), 64'h0);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_tid !== 9'd20) begin
      n_fail++; $display("[TB] FAIL full_head: got v=%b tid=%0d, required v=1 tid=20", rsp_valid, rsp_tid);
    end
    rsp_ready = 1'b1;
    for (int k = 21; k <= 24; k++) begin
      idle(1);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_tid !== 9'(k)) begin
        n_fail++; $display("[TB] FAIL pushpop_tid: got v=%b tid=%0d, required v=1 tid=%0d",
                           rsp_valid, rsp_tid, k);
      end
    end
    idle(1);
    n_checks++;
    if (rsp_valid !== 1'b0 || err_overflow !== 1'b0) begin
      n_fail++; $display("[TB] FAIL pushpop_end: got v=%b err=%b, required v=0 err=0",
                         rsp_valid, err_overflow);
    end
  endtask

  task automatic test_overflow;
    rsp_ready = 1'b0;
    for (int k = 1; k <= 5; k++)
      issue(1'b0, 16'h0000, 2'd1, 9'(k), 64'h0);
    n_checks++;
    if (err_overflow !== 1'b0) begin
      n_fail++; $display("[TB] FAIL ovf_early: got %b, required 0", err_overflow);
    end
    idle(1);
    n_checks++;
    if (err_overflow !== 1'b1) begin
      n_fail++; $display("[TB] FAIL ovf_flag: got %b, required 1", err_overflow);
    end
    rsp_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_tid !== 9'(k)) begin
        n_fail++; $display("[TB] FAIL ovf_drain: got v=%b tid=%0d, required v=1 tid=%0d",
                           rsp_valid, rsp_tid, k);
      end
      idle(1);
    end
    n_checks++;
    if (rsp_valid !== 1'b0 || err_overflow !== 1'b1) begin
      n_fail++; $display("[TB] FAIL ovf_after_drain: got v=%b err=%b, required v=0 err=1",
                         rsp_valid, err_overflow);
    end
  endtask

  task automatic test_reset_inflight;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      issue(1'b0, 16'h0000, 2'd1, 9'(30 + k), 64'h0);
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL queued_before_reset: got %b, required 1", rsp_valid);
    end
    reset     = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0000;
    req_tid   = 9'd33;
    idle(1);
    n_checks++;
    if (rsp_valid !== 1'b0 || err_overflow !== 1'b0 || csr_ctl !== 64'h0) begin
      n_fail++; $display("[TB] FAIL reset_flush: got v=%b err=%b ctl=%h, required all 0",
                         rsp_valid, err_overflow, csr_ctl);
    end
    reset     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_fail++; $display("[TB] FAIL stale_rsp: got valid %b tid=%0d, required 0", rsp_valid, rsp_tid);
      end
      idle(1);
    end
    issue(1'b0, 16'h0006, 2'd1, 9'h40, 64'h0);
    idle(1);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 64'h0) begin
      n_fail++; $display("[TB] FAIL scratch_after_reset: got v=%b data=%h, required v=1 data=0",
                         rsp_valid, rsp_data);
    end
    idle(2);
  endtask

  task automatic test_timestamp;
    logic [63:0] d1;
    logic [63:0] d2;
    rsp_ready = 1'b1;
    issue(1'b0, 16'h000C, 2'd1, 9'h50, 64'h0);
    idle(1);
    d1 = rsp_data;
    idle(8);
    issue(1'b0, 16'h000C, 2'd1, 9'h51, 64'h0);
    idle(1);
    d2 = rsp_data;
`ifdef CCIP_MMIO_TIMESTAMP_EN
    n_checks++;
    if (d2 - d1 !== 64'd10) begin
      n_fail++; $display("[TB] FAIL timestamp_delta: got %0d, required 10", d2 - d1);
    end
    n_checks++;
    if (d1 === 64'h0) begin
      n_fail++; $display("[TB] FAIL timestamp_running: got %h, required nonzero", d1);
    end
`else
    n_checks++;
    if (d1 !== 64'h0 || d2 !== 64'h0) begin
      n_fail++; $display("[TB] FAIL timestamp_disabled: got %h and %h, required 0 and 0", d1, d2);
    end
`endif
    idle(2);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_len    = '0;
    req_tid    = '0;
    req_data   = '0;
    rsp_ready  = 1'b0;
    afu_status = STAT;
    $display("[TB] starting");
    test_reset();
    test_read_dfh();
    test_scratch();
    test_ctl();
    test_ro_and_unmapped();
    test_back_to_back();
    test_full_push_pop();
    test_overflow();
    test_reset_inflight();
    test_timestamp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
